// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame source.
// Contents: frame geometry, byte-index type, FSM state encoding and the
// 5x8 digit glyph table (column-major, bit 0 = top row of the glyph).
package oled_pkg;

  localparam int OLED_COLS   = 128;
  localparam int OLED_PAGES  = 8;
  localparam int FRAME_BYTES = OLED_COLS * OLED_PAGES;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef logic [IDX_W-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Digits 0-9, five columns each; column byte bit n lights glyph row n.
  localparam logic [0:9][0:4][7:0] FONT = '{
    '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E},  // 0
    '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00},  // 1
    '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46},  // 2
    '{8'h21, 8'h41, 8'h45, 8'h4B, 8'h31},  // 3
    '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10},  // 4
    '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39},  // 5
    '{8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30},  // 6
    '{8'h01, 8'h71, 8'h09, 8'h05, 8'h03},  // 7
    '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36},  // 8
    '{8'h06, 8'h49, 8'h49, 8'h29, 8'h1E}   // 9
  };

endpackage

// File: rtl/digit_font_rom.sv
// Combinational digit glyph lookup.
// Ports:
//   digit     in  4  digit to draw; 10-15 give a blank column
//   col       in  3  glyph column 0-4; 5-7 give a blank column
//   font_byte out 8  column pixels, bit 0 = top row
module digit_font_rom
  import oled_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] col,
  output logic [7:0] font_byte
);

  always_comb begin
    font_byte = 8'h00;
    if (digit <= 4'd9 && col <= 3'd4) begin
      font_byte = FONT[digit][col];
    end
  end

endmodule

// File: rtl/oled_frame_source.sv
// Renders one SSD1306 frame (pages x columns, horizontal addressing) per
// request as a valid/ready byte stream for the SPI serializer.
// Each byte is the OR of the ball pixel, the paddle row (page 7, bit 7) and
// an optional score digit in page 0, columns 0-4. Game inputs are captured
// once per frame so a frame is never torn.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              stream frames back-to-back while high
//   ball_x, ball_y      ball column 0-127 / row 0-63
//   paddle_x            paddle left column
//   score               digit 0-9, 10-15 blank
//   out_data/out_valid  display byte and its qualifier
//   out_ready           serializer accepts on valid && ready
//   out_first/out_last  mark byte 0 and the final byte of the frame
//   busy                high while in SNAP or STREAM
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame in flight, waiting for enable
// ST_SNAP   | capture game inputs, load byte 0 on the exit edge
// ST_STREAM | present byte idx; advance on each accepted byte
module oled_frame_source
  import oled_pkg::*;
#(
  parameter int COLS       = OLED_COLS,
  parameter int PAGES      = OLED_PAGES,
  parameter int PADDLE_LEN = 16,
  parameter bit SCORE_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] ball_x,
  input  logic [5:0] ball_y,
  input  logic [6:0] paddle_x,
  input  logic [3:0] score,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic       busy
);

  localparam int FRAME_N = COLS * PAGES;
  localparam int FIDX_W  = $clog2(FRAME_N);
  localparam int COL_W   = $clog2(COLS);
  localparam int PAGE_W  = FIDX_W - COL_W;

  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(FRAME_N - 1);
  localparam logic [FIDX_W-1:0] IDX_ONE  = FIDX_W'(1);

  state_e             state_q, state_d;
  logic [FIDX_W-1:0]  idx_q, idx_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [6:0]         snap_bx_q, snap_bx_d;
  logic [5:0]         snap_by_q, snap_by_d;
  logic [6:0]         snap_px_q, snap_px_d;
  logic [3:0]         snap_sc_q, snap_sc_d;

  // Render path: the byte that will be loaded on the next edge.
  logic [6:0]         src_bx, src_px;
  logic [5:0]         src_by;
  logic [3:0]         src_sc;
  logic [FIDX_W-1:0]  rnd_idx;
  logic [COL_W-1:0]   rnd_col;
  logic [PAGE_W-1:0]  rnd_page;
  logic [7:0]         paddle_end;
  logic               ball_hit, paddle_hit, score_hit;
  logic [7:0]         font_byte;
  logic [7:0]         render_byte;

  // In SNAP the snapshot registers are being written on the same edge that
  // loads byte 0, so byte 0 is rendered straight from the live inputs.
  always_comb begin
    if (state_q == ST_SNAP) begin
      src_bx  = ball_x;
      src_by  = ball_y;
      src_px  = paddle_x;
      src_sc  = score;
      rnd_idx = '0;
    end else begin
      src_bx  = snap_bx_q;
      src_by  = snap_by_q;
      src_px  = snap_px_q;
      src_sc  = snap_sc_q;
      rnd_idx = idx_q + IDX_ONE;
    end
  end

  assign rnd_col  = rnd_idx[COL_W-1:0];
  assign rnd_page = rnd_idx[FIDX_W-1:COL_W];

  digit_font_rom u_font (
    .digit     (src_sc),
    .col       (rnd_col[2:0]),
    .font_byte (font_byte)
  );

  // 8-bit end column: the paddle clips at the right edge instead of wrapping.
  assign paddle_end = {1'b0, src_px} + 8'(PADDLE_LEN);

  always_comb begin
    ball_hit    = (rnd_page == PAGE_W'(src_by[5:3])) && (rnd_col == COL_W'(src_bx));
    paddle_hit  = (rnd_page == PAGE_W'(PAGES - 1))
                  && (rnd_col >= COL_W'(src_px))
                  && ({1'b0, rnd_col} < paddle_end);
    score_hit   = SCORE_EN && (rnd_page == '0) && (rnd_col < COL_W'(5));
    render_byte = 8'h00;
    if (ball_hit)   render_byte = render_byte | (8'h01 << src_by[2:0]);
    if (paddle_hit) render_byte = render_byte | 8'h80;
    if (score_hit)  render_byte = render_byte | font_byte;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    snap_bx_d   = snap_bx_q;
    snap_by_d   = snap_by_q;
    snap_px_d   = snap_px_q;
    snap_sc_d   = snap_sc_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SNAP;
      end

      ST_SNAP: begin
        snap_bx_d   = ball_x;
        snap_by_d   = ball_y;
        snap_px_d   = paddle_x;
        snap_sc_d   = score;
        idx_d       = '0;
        out_data_d  = render_byte;
        out_valid_d = 1'b1;
        out_first_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = ST_STREAM;
      end

      ST_STREAM: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = enable ? ST_SNAP : ST_IDLE;
          end else begin
            idx_d       = rnd_idx;
            out_data_d  = render_byte;
            out_first_d = 1'b0;
            out_last_d  = (rnd_idx == LAST_IDX);
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      snap_bx_q   <= '0;
      snap_by_q   <= '0;
      snap_px_q   <= '0;
      snap_sc_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      snap_bx_q   <= snap_bx_d;
      snap_by_q   <= snap_by_d;
      snap_px_q   <= snap_px_d;
      snap_sc_q   <= snap_sc_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oled_frame_source.sv
module tb_oled_frame_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [6:0] ball_x;
  logic [5:0] ball_y;
  logic [6:0] paddle_x;
  logic [3:0] score;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  oled_frame_source dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .paddle_x  (paddle_x),
    .score     (score),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] font_tb [0:9][0:4] = '{
    '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E},
    '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00},
    '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46},
    '{8'h21, 8'h41, 8'h45, 8'h4B, 8'h31},
    '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10},
    '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39},
    '{8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30},
    '{8'h01, 8'h71, 8'h09, 8'h05, 8'h03},
    '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36},
    '{8'h06, 8'h49, 8'h49, 8'h29, 8'h1E}
  };

  logic [7:0] got_bytes [0:1023];
  logic [7:0] ref_bytes [0:1023];
  int         acc_n;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_first, prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame contents from the drawing rules: a pixel image of 128x64 viewed
  // as pages of 8 rows.
  function automatic logic [7:0] model_byte(input int idx, input int bx, input int by,
                                            input int px, input int sc);
    int page = idx / 128;
    int col  = idx % 128;
    logic [7:0] b = 8'h00;
    for (int bit_n = 0; bit_n < 8; bit_n++) begin
      int row = page * 8 + bit_n;
      if (row == by && col == bx) b[bit_n] = 1'b1;
    end
    if (page == 7 && col >= px && col < px + 16) b[7] = 1'b1;
    if (page == 0 && col < 5 && sc <= 9) b = b | font_tb[sc][col];
    return b;
  endfunction

  // Consume accepted bytes until acc_n reaches stop_at. Called and returns
  // at a falling edge; on return the final byte is being accepted.
  task automatic stream_bytes(input int bx, input int by, input int px, input int sc,
                              input int ready_pct, input int stop_at);
    int budget = 12000;
    bit r;
    while (acc_n < stop_at) begin
      if (budget == 0) begin
        chk("stream_timeout", acc_n, stop_at);
        return;
      end
      budget--;
      @(negedge clk);
      r = ($urandom_range(0, 99) < ready_pct);
      if (out_valid) begin
        if (prev_stall) begin
          chk("hold_data", out_data, prev_data);
          chk("hold_first", out_first, prev_first);
          chk("hold_last", out_last, prev_last);
        end
        out_ready = r;
        if (r) begin
          chk("byte", out_data, model_byte(acc_n, bx, by, px, sc));
          chk("first_flag", out_first, (acc_n == 0));
          chk("last_flag", out_last, (acc_n == 1023));
          got_bytes[acc_n] = out_data;
          acc_n++;
        end
        prev_stall = !r;
        prev_data  = out_data;
        prev_first = out_first;
        prev_last  = out_last;
      end else begin
        if (acc_n > 0) chk("valid_mid", out_valid, 1);
        prev_stall = 1'b0;
        out_ready  = r;
      end
    end
  endtask

  // Called at a falling edge with the DUT idle (or in reset); checks the
  // two-edge start latency.
  task automatic start_frame(input int bx, input int by, input int px, input int sc);
    rst        = 1'b0;
    ball_x     = 7'(bx);
    ball_y     = 6'(by);
    paddle_x   = 7'(px);
    score      = 4'(sc);
    enable     = 1'b1;
    out_ready  = 1'b0;
    acc_n      = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk("lat_snap_valid", out_valid, 0);
    chk("lat_snap_busy", busy, 1);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_first", out_first, 1);
    chk("lat_busy", busy, 1);
  endtask

  task automatic frame_end(input bit keep_en);
    @(negedge clk);
    out_ready = 1'b0;
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, keep_en);
    if (keep_en) begin
      @(negedge clk);
      chk("bubble_valid", out_valid, 1);
      chk("bubble_first", out_first, 1);
      acc_n      = 0;
      prev_stall = 1'b0;
    end
  endtask

  task automatic do_frame(input int bx, input int by, input int px, input int sc,
                          input int ready_pct);
    start_frame(bx, by, px, sc);
    stream_bytes(bx, by, px, sc, ready_pct, 500);
    enable = 1'b0;
    stream_bytes(bx, by, px, sc, ready_pct, 1024);
    frame_end(1'b0);
  endtask

  initial begin
    logic [7:0] glyph8 [0:4];
    int bx, by, px, sc, nbx, npx;
    glyph8 = '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36};

    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    ball_x = '0; ball_y = '0; paddle_x = '0; score = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);

    // Reference frame, full throughput.
    do_frame(10, 21, 100, 15, 100);
    for (int i = 0; i < 1024; i++) ref_bytes[i] = got_bytes[i];
    chk("a_ball266", got_bytes[266], 8'h20);
    chk("a_pad996", got_bytes[996], 8'h80);
    chk("a_pad1011", got_bytes[1011], 8'h80);
    chk("a_pad1012", got_bytes[1012], 8'h00);
    chk("a_pad995", got_bytes[995], 8'h00);

    // Paddle clipping at the right edge.
    do_frame(3, 5, 120, 15, 100);
    chk("b_pad1016", got_bytes[1016], 8'h80);
    chk("b_pad1023", got_bytes[1023], 8'h80);
    chk("b_pad1015", got_bytes[1015], 8'h00);
    chk("b_pad896", got_bytes[896], 8'h00);

    // Ball overlapping the paddle.
    do_frame(105, 62, 100, 15, 100);
    chk("b_ovl1001", got_bytes[1001], 8'hC0);

    // Score digit and blank score.
    do_frame(60, 40, 0, 8, 100);
    for (int i = 0; i < 5; i++) chk("score8", got_bytes[i], glyph8[i]);
    do_frame(60, 40, 0, 12, 100);
    for (int i = 0; i < 5; i++) chk("score12", got_bytes[i], 8'h00);

    // Random backpressure must give the same stream.
    do_frame(10, 21, 100, 15, 50);
    chk("stall_count", acc_n, 1024);
    for (int i = 0; i < 1024; i++) chk("stall_same", got_bytes[i], ref_bytes[i]);

    // Inputs changed mid-frame are deferred to the next frame.
    bx = $urandom_range(0, 127); by = $urandom_range(0, 63);
    px = $urandom_range(0, 127); sc = $urandom_range(0, 15);
    nbx = (bx + 37) % 128; npx = (px + 51) % 128;
    start_frame(bx, by, px, sc);
    stream_bytes(bx, by, px, sc, 70, 500);
    ball_x = 7'(nbx); paddle_x = 7'(npx);
    stream_bytes(bx, by, px, sc, 70, 1024);
    frame_end(1'b1);
    stream_bytes(nbx, by, npx, sc, 70, 500);
    enable = 1'b0;
    stream_bytes(nbx, by, npx, sc, 70, 1024);
    frame_end(1'b0);

    // Reset mid-frame.
    start_frame(10, 21, 100, 3);
    stream_bytes(10, 21, 100, 3, 100, 300);
    @(negedge clk);
    chk("rst_pre_data", out_data, model_byte(300, 10, 21, 100, 3));
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_first", out_first, 0);
    chk("rst_mid_data", out_data, 0);
    start_frame(77, 9, 30, 5);
    stream_bytes(77, 9, 30, 5, 100, 500);
    enable = 1'b0;
    stream_bytes(77, 9, 30, 5, 100, 1024);
    frame_end(1'b0);

    // Random frames with random backpressure.
    for (int k = 0; k < 3; k++) begin
      do_frame($urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 127),
               $urandom_range(0, 15), $urandom_range(30, 90));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
